dadder_driver: RTL and testbench
================================

Name: dadder_driver

Overview:
- Command-side initiator for the decimal adder/subtracter (one clock, 1-cycle registered result, `en`/`vld_out` strobes).
- Accepts tagged add/subtract commands over a valid/ready interface and issues one operation at a time to the adder by pulsing its enable.
- Captures the adder result and returns it through a small response FIFO with a valid/ready interface.
- Sits between a register/bus front-end and the adder instance.

Parameters:
- DATA_WIDTH, 8: operand/result width; must match the attached adder.
- TAG_WIDTH, 4: width of the command tag echoed in the response.
- RSP_DEPTH, 4: response FIFO depth; power of 2, ≥ 2.
- TIMEOUT, 15: cycles to wait for the adder valid before declaring an error; 1..255.

Ports:
- clk  in  1  Clock
- reset_n  in  1  Asynchronous active-low reset
- cmd_vld  in  1  Command valid
- cmd_rdy  out  1  Command ready
- cmd_op  in  1  1 = add, 0 = subtract
- cmd_carry  in  1  Carry-in, used for add only
- cmd_a  in  DATA_WIDTH  Operand A
- cmd_b  in  DATA_WIDTH  Operand B
- cmd_tag  in  TAG_WIDTH  Command tag
- dadder_en  out  1  Adder enable pulse
- dadder_op  out  1  Adder operation
- dadder_carry_in  out  1  Adder carry-in
- dadder_op_a  out  DATA_WIDTH  Adder operand A
- dadder_op_b  out  DATA_WIDTH  Adder operand B
- dadder_vld  in  1  Adder result valid
- dadder_of  in  1  Adder overflow (add) / negative sign (subtract)
- dadder_data  in  DATA_WIDTH  Adder result
- rsp_vld  out  1  Response valid (FIFO not empty)
- rsp_rdy  in  1  Response ready
- rsp_data  out  DATA_WIDTH  Result
- rsp_of  out  1  Overflow/sign
- rsp_err  out  1  Timeout error; rsp_data = 0 and rsp_of = 0 when set
- rsp_tag  out  TAG_WIDTH  Echoed tag
- busy  out  1  State is not IDLE

Behaviour:
- Reset (async, reset_n = 0):
  - State goes to IDLE; FIFO is emptied.
  - All outputs are 0: cmd_rdy, dadder_*, rsp_*, busy.
  - Outputs also read 0 in the first cycle after deassertion. cmd_rdy may rise from the second cycle.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - cmd_rdy = 1 only when FIFO occupancy < RSP_DEPTH. The in-flight op is counted as a reserved slot, so a captured result can never be dropped.
  - A transfer occurs when cmd_vld & cmd_rdy at a clk edge. op/carry/a/b/tag are latched and the state goes to ISSUE.
  - cmd_carry is forced to 0 when cmd_op = 0.
- ISSUE, exactly 1 cycle:
  - dadder_en = 1 with the latched operands on dadder_op_*; cmd_rdy = 0.
  - Next state is WAIT; the timeout counter loads 0.
- WAIT:
  - dadder_en = 0; operands hold their values; cmd_rdy = 0.
  - On dadder_vld = 1: push {dadder_data, dadder_of, err = 0, tag}, go to IDLE.
  - The expected case is dadder_vld in the first WAIT cycle (adder latency 1). Longer latencies up to TIMEOUT are accepted.
  - If the counter reaches TIMEOUT without dadder_vld: push {0, 0, err = 1, tag}, go to IDLE.
  - dadder_vld seen in IDLE or ISSUE is ignored (no push).
- Command throughput: one command per 3 cycles at best (IDLE→ISSUE→WAIT→IDLE).
- Response FIFO:
  - First-word fall-through; rsp_* show the head entry.
  - A pop occurs on rsp_vld & rsp_rdy.
  - A push and pop in the same cycle leave occupancy unchanged.
  - Read and write pointers wrap modulo RSP_DEPTH.
  - Pushes cannot occur when full, by construction of the cmd_rdy rule.
  - A pop from an empty FIFO is ignored.
- Reset mid-operation: the in-flight op is abandoned, with no response generated; FIFO contents are lost; dadder_en drops immediately.

Optional Feature:
- Macro: DADDER_DRIVER_STATS_EN.
- Defined:
  - Adds outputs stat_ops, stat_of and stat_err, each 16 bits.
  - stat_ops increments on each ISSUE.
  - stat_of increments on each push with of = 1.
  - stat_err increments on each timeout push.
  - All three saturate at 0xFFFF and reset to 0.
  - Adds input stat_clr (1 bit), which zeroes all three synchronously. stat_clr takes priority over a same-cycle increment.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Add, a = 8'h25, b = 8'h30, carry = 1, tag = 3, adder model answers 1 cycle after en → dadder_en high exactly 1 cycle; response data = 8'h56, of = 0, err = 0, tag = 3; cmd_rdy low for 2 cycles.
- Subtract, a = 8'h10, b = 8'h20, cmd_carry = 1 → dadder_carry_in = 0; response of = 1, data from model, tag echoed.
- Adder model never asserts vld, TIMEOUT = 15 → err response with data = 0 and tag echoed exactly 16 cycles after the ISSUE cycle; busy drops on the next cycle.
- rsp_rdy held 0, 5 back-to-back commands with RSP_DEPTH = 4 → 4 responses queued, cmd_rdy stays 0 with the 5th pending; raising rsp_rdy drains in order; 5th completes with correct tag.
- Assert reset_n = 0 during WAIT with 2 responses queued → all outputs 0 asynchronously; after release, no stale responses and a new command completes normally.
- With DADDER_DRIVER_STATS_EN: 3 adds (1 overflowing, a = 8'hFF, b = 8'h01) plus 1 timeout → stat_ops = 4, stat_of = 1, stat_err = 1; stat_clr → all 0 next cycle.

Source files
------------

// File: rtl/dadder_driver.sv
// dadder_driver: command-side initiator for the decimal adder/subtracter.
//
// Accepts tagged add/subtract commands on a valid/ready interface, runs one
// operation at a time through the adder (IDLE -> ISSUE -> WAIT), and returns
// each result, or a timeout error, through a first-word fall-through response
// FIFO. Every output is driven directly by a flop.
//
// Optional feature macro: DADDER_DRIVER_STATS_EN adds the stat_* counters and
// the stat_clr input.
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   cmd_vld/cmd_rdy        command handshake
//   cmd_op/carry/a/b/tag   command payload (op: 1 = add, 0 = subtract)
//   dadder_*  (out)        enable pulse and operands to the adder
//   dadder_vld/of/data     adder result
//   rsp_vld/rsp_rdy        response handshake (FIFO head)
//   rsp_data/of/err/tag    response payload
//   busy                   an operation is in flight
//   stat_* (optional)      16-bit saturating op/overflow/error counters

module dadder_driver #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TAG_WIDTH  = 4,
  parameter int unsigned RSP_DEPTH  = 4,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic                  cmd_op,
  input  logic                  cmd_carry,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic [TAG_WIDTH-1:0]  cmd_tag,
  output logic                  dadder_en,
  output logic                  dadder_op,
  output logic                  dadder_carry_in,
  output logic [DATA_WIDTH-1:0] dadder_op_a,
  output logic [DATA_WIDTH-1:0] dadder_op_b,
  input  logic                  dadder_vld,
  input  logic                  dadder_of,
  input  logic [DATA_WIDTH-1:0] dadder_data,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_of,
  output logic                  rsp_err,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  busy
`ifdef DADDER_DRIVER_STATS_EN
  ,
  input  logic                  stat_clr,
  output logic [15:0]           stat_ops,
  output logic [15:0]           stat_of,
  output logic [15:0]           stat_err
`endif
);

  localparam int unsigned PtrW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(RSP_DEPTH + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(RSP_DEPTH);
  localparam logic [7:0] TmoC = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  of;
    logic                  err;
    logic [TAG_WIDTH-1:0]  tag;
  } rsp_t;

  state_e r_state, w_state_d;

  // Low for the first edge after reset release so cmd_rdy stays 0 one extra cycle.
  logic r_init;

  logic                  r_op, r_carry;
  logic [DATA_WIDTH-1:0] r_a, r_b;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic [7:0]            r_tmo_cnt;

  logic r_cmd_rdy, r_en, r_busy, r_rsp_vld;
  rsp_t r_head;

  rsp_t            r_mem [RSP_DEPTH];
  logic [PtrW-1:0] r_wr_ptr, r_rd_ptr, w_rd_ptr_d;
  logic [CntW-1:0] r_count, w_count_d;

  logic w_xfer, w_tmo, w_push, w_pop;
  rsp_t w_push_entry, w_head_d;
  logic w_cmd_rdy_d, w_en_d, w_busy_d, w_rsp_vld_d;

  assign w_xfer = (r_state == StIdle) && cmd_vld && r_cmd_rdy;
  assign w_tmo  = (r_tmo_cnt == TmoC);
  assign w_push = (r_state == StWait) && (dadder_vld || w_tmo);
  assign w_pop  = r_rsp_vld && rsp_rdy;

  // A real result wins over a timeout detected in the same cycle.
  always_comb begin
    w_push_entry     = '0;
    w_push_entry.tag = r_tag;
    if (dadder_vld) begin
      w_push_entry.data = dadder_data;
      w_push_entry.of   = dadder_of;
    end else begin
      w_push_entry.err  = 1'b1;
    end
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_xfer) w_state_d = StIssue;
      StIssue: w_state_d = StWait;
      StWait:  if (dadder_vld || w_tmo) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs. cmd_rdy only rises in IDLE, where
  // nothing is in flight, so any accepted op always has a free FIFO slot.
  always_comb begin
    w_cmd_rdy_d = r_init && (w_state_d == StIdle) && (w_count_d < DepthC);
    w_en_d      = (w_state_d == StIssue);
    w_busy_d    = (w_state_d != StIdle);
    w_rsp_vld_d = (w_count_d != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_init    <= 1'b0;
      r_cmd_rdy <= 1'b0;
      r_en      <= 1'b0;
      r_busy    <= 1'b0;
      r_rsp_vld <= 1'b0;
      r_head    <= '0;
    end else begin
      r_init    <= 1'b1;
      r_cmd_rdy <= w_cmd_rdy_d;
      r_en      <= w_en_d;
      r_busy    <= w_busy_d;
      r_rsp_vld <= w_rsp_vld_d;
      r_head    <= w_head_d;
    end
  end

  // Command latch; these flops also drive the adder operand ports.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op    <= 1'b0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_tag   <= '0;
    end else if (w_xfer) begin
      r_op    <= cmd_op;
      r_carry <= cmd_op & cmd_carry;
      r_a     <= cmd_a;
      r_b     <= cmd_b;
      r_tag   <= cmd_tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == StIssue) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == StWait) && !w_push) begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
  end

  // ---------------------------------------------------------- response FIFO
  always_comb begin
    w_count_d = r_count;
    if (w_push && !w_pop) begin
      w_count_d = r_count + CntW'(1);
    end else if (!w_push && w_pop) begin
      w_count_d = r_count - CntW'(1);
    end
  end

  assign w_rd_ptr_d = w_pop ? (r_rd_ptr + PtrW'(1)) : r_rd_ptr;

  // Head after this edge: the entry being pushed becomes the head when it
  // lands in the slot the read pointer will point at (FIFO empty after pop).
  always_comb begin
    w_head_d = '0;
    if (w_count_d != '0) begin
      if (w_push && (r_wr_ptr == w_rd_ptr_d)) begin
        w_head_d = w_push_entry;
      end else begin
        w_head_d = r_mem[w_rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_push_entry;
  end

  assign cmd_rdy         = r_cmd_rdy;
  assign dadder_en       = r_en;
  assign dadder_op       = r_op;
  assign dadder_carry_in = r_carry;
  assign dadder_op_a     = r_a;
  assign dadder_op_b     = r_b;
  assign rsp_vld         = r_rsp_vld;
  assign rsp_data        = r_head.data;
  assign rsp_of          = r_head.of;
  assign rsp_err         = r_head.err;
  assign rsp_tag         = r_head.tag;
  assign busy            = r_busy;

`ifdef DADDER_DRIVER_STATS_EN
  logic [15:0] r_stat_ops, r_stat_of, r_stat_err;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_ops <= '0;
      r_stat_of  <= '0;
      r_stat_err <= '0;
    end else if (stat_clr) begin
      r_stat_ops <= '0;
      r_stat_of  <= '0;
      r_stat_err <= '0;
    end else begin
      if ((r_state == StIssue) && (r_stat_ops != 16'hFFFF)) begin
        r_stat_ops <= r_stat_ops + 16'd1;
      end
      if (w_push && w_push_entry.of && (r_stat_of != 16'hFFFF)) begin
        r_stat_of <= r_stat_of + 16'd1;
      end
      if (w_push && w_push_entry.err && (r_stat_err != 16'hFFFF)) begin
        r_stat_err <= r_stat_err + 16'd1;
      end
    end
  end

  assign stat_ops = r_stat_ops;
  assign stat_of  = r_stat_of;
  assign stat_err = r_stat_err;
`endif

endmodule

// File: tb/tb_dadder_driver.sv
// Bench for dadder_driver: a behavioural decimal adder answers one cycle
// after each enable (or never, for timeouts); responses are checked against
// an expectation queue filled as commands are accepted.
module tb_dadder_driver;
  localparam int unsigned DW = 8;
  localparam int unsigned TW = 4;
  localparam int unsigned EW = DW + 2 + TW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          cmd_vld = 1'b0, cmd_rdy, cmd_op = 1'b0, cmd_carry = 1'b0;
  logic [DW-1:0] cmd_a = '0, cmd_b = '0;
  logic [TW-1:0] cmd_tag = '0;
  logic          dadder_en, dadder_op, dadder_carry_in;
  logic [DW-1:0] dadder_op_a, dadder_op_b;
  logic          dadder_vld, dadder_of;
  logic [DW-1:0] dadder_data;
  logic          rsp_vld, rsp_rdy = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          rsp_of, rsp_err;
  logic [TW-1:0] rsp_tag;
  logic          busy;
`ifdef DADDER_DRIVER_STATS_EN
  logic          stat_clr = 1'b0;
  logic [15:0]   stat_ops, stat_of, stat_err;
`endif

  always #5 clk = ~clk;

  dadder_driver #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .RSP_DEPTH(4), .TIMEOUT(15)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_op(cmd_op), .cmd_carry(cmd_carry),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .dadder_en(dadder_en), .dadder_op(dadder_op), .dadder_carry_in(dadder_carry_in),
    .dadder_op_a(dadder_op_a), .dadder_op_b(dadder_op_b),
    .dadder_vld(dadder_vld), .dadder_of(dadder_of), .dadder_data(dadder_data),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_data(rsp_data), .rsp_of(rsp_of),
    .rsp_err(rsp_err), .rsp_tag(rsp_tag), .busy(busy)
`ifdef DADDER_DRIVER_STATS_EN
    , .stat_clr(stat_clr), .stat_ops(stat_ops), .stat_of(stat_of), .stat_err(stat_err)
`endif
  );

  // ------------------------------------------------------------ adder model
  function automatic logic [8:0] bcd_add(input logic [7:0] a, input logic [7:0] b,
                                         input logic cin);
    logic [4:0] s;
    logic       c;
    logic [7:0] r;
    c = cin;
    r = '0;
    for (int d = 0; d < 2; d++) begin
      s = {1'b0, a[d*4+:4]} + {1'b0, b[d*4+:4]} + {4'b0, c};
      if (s > 5'd9) begin
        r[d*4+:4] = 4'(s - 5'd10);
        c = 1'b1;
      end else begin
        r[d*4+:4] = s[3:0];
        c = 1'b0;
      end
    end
    return {c, r};
  endfunction

  // Subtract returns the BCD magnitude with the sign flag set when negative.
  function automatic logic [8:0] bcd_sub(input logic [7:0] a, input logic [7:0] b);
    int x, y, d;
    logic neg;
    x = int'(a[7:4]) * 10 + int'(a[3:0]);
    y = int'(b[7:4]) * 10 + int'(b[3:0]);
    d = x - y;
    neg = (d < 0);
    if (neg) d = -d;
    return {neg, 4'(d / 10), 4'(d % 10)};
  endfunction

  logic          model_on = 1'b1;
  logic          spur_vld = 1'b0;
  logic          m_vld = 1'b0, m_of = 1'b0;
  logic [DW-1:0] m_data = '0;

  always @(posedge clk) begin
    m_vld <= dadder_en && model_on;
    if (dadder_en) begin
      {m_of, m_data} <= dadder_op ? bcd_add(dadder_op_a, dadder_op_b, dadder_carry_in)
                                  : bcd_sub(dadder_op_a, dadder_op_b);
    end
  end

  assign dadder_vld  = m_vld | spur_vld;
  assign dadder_of   = m_of;
  assign dadder_data = m_data;

  // ------------------------------------------------------------ checking
  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Every cycle advance goes through here: a response that will pop at the
  // coming edge is compared first, then we move to the next falling edge.
  task automatic tick();
    logic [EW-1:0] act, exp;
    if (rsp_vld && rsp_rdy) begin
      act = {rsp_data, rsp_of, rsp_err, rsp_tag};
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got %0h, want none", act);
      end else begin
        exp = sb_q.pop_front();
        if (act !== exp) begin
          n_fail++;
          $display("FAIL rsp {data,of,err,tag}: got %0h, want %0h", act, exp);
        end
      end
    end
    @(negedge clk);
  endtask

  // Returns at the falling edge of the ISSUE cycle.
  task automatic send(input logic op, input logic carry, input logic [7:0] a,
                      input logic [7:0] b, input logic [3:0] tag,
                      input logic [7:0] ed, input logic eo, input logic ee);
    int n;
    n = 0;
    cmd_op = op; cmd_carry = carry; cmd_a = a; cmd_b = b; cmd_tag = tag;
    cmd_vld = 1'b1;
    while (!cmd_rdy && n < 100) begin
      tick();
      n++;
    end
    check("send_cmd_rdy", 32'(cmd_rdy), 1);
    if (!cmd_rdy) begin
      cmd_vld = 1'b0;
      return;
    end
    sb_q.push_back({ed, eo, ee, tag});
    tick();
    cmd_vld = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || busy) && n < 200) begin
      tick();
      n++;
    end
    check("drain_pending", 32'(sb_q.size()), 0);
  endtask

  typedef struct {
    logic          op;
    logic          carry;
    logic [7:0]    a;
    logic [7:0]    b;
    logic [3:0]    tag;
    logic [7:0]    exp_data;
    logic          exp_of;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{1'b1, 1'b0, 8'h45, 8'h55, 4'h6, 8'h00, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 8'h99, 8'h01, 4'h7, 8'h98, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'h09, 8'h01, 4'h8, 8'h10, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'h50, 8'h50, 4'h9, 8'h00, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 8'h99, 8'h99, 4'hB, 8'h99, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 8'h12, 8'h34, 4'hD, 8'h46, 1'b0};

    // Reset state
    tick(); tick();
    check("rst_cmd_rdy", 32'(cmd_rdy), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_dadder_en", 32'(dadder_en), 0);
    check("rst_rsp_vld", 32'(rsp_vld), 0);
    check("rst_rsp_data", 32'(rsp_data), 0);
    reset_n = 1'b1;
    tick();
    check("rdy_first_cycle", 32'(cmd_rdy), 0);
    tick();
    check("rdy_second_cycle", 32'(cmd_rdy), 1);

    // Add with carry, cycle by cycle
    send(1'b1, 1'b1, 8'h25, 8'h30, 4'h3, 8'h56, 1'b0, 1'b0);
    check("issue_en", 32'(dadder_en), 1);
    check("issue_rdy", 32'(cmd_rdy), 0);
    check("issue_busy", 32'(busy), 1);
    check("issue_ops", 32'({dadder_op, dadder_carry_in, dadder_op_a, dadder_op_b}),
          32'({1'b1, 1'b1, 8'h25, 8'h30}));
    tick();
    check("wait_en", 32'(dadder_en), 0);
    check("wait_rdy", 32'(cmd_rdy), 0);
    check("wait_op_a_hold", 32'(dadder_op_a), 32'h25);
    tick();
    check("done_rdy", 32'(cmd_rdy), 1);
    check("done_busy", 32'(busy), 0);
    check("done_rsp_vld", 32'(rsp_vld), 1);
    wait_drain();

    // Subtract: carry must be forced to 0
    send(1'b0, 1'b1, 8'h10, 8'h20, 4'h5, 8'h10, 1'b1, 1'b0);
    check("sub_carry_in", 32'(dadder_carry_in), 0);
    check("sub_op", 32'(dadder_op), 0);
    wait_drain();

    for (int i = 0; i < 6; i++) begin
      send(vecs[i].op, vecs[i].carry, vecs[i].a, vecs[i].b, vecs[i].tag,
           vecs[i].exp_data, vecs[i].exp_of, 1'b0);
      wait_drain();
    end

    // Adder valid while idle is ignored
    spur_vld = 1'b1;
    tick();
    spur_vld = 1'b0;
    tick();
    check("spur_no_push", 32'(rsp_vld), 0);
    check("spur_not_busy", 32'(busy), 0);

    // Timeout: counter hits 15 sixteen cycles after ISSUE, response next cycle
    model_on = 1'b0;
    send(1'b1, 1'b0, 8'h12, 8'h34, 4'hA, 8'h00, 1'b0, 1'b1);
    check("tmo_issue_en", 32'(dadder_en), 1);
    for (int i = 0; i < 16; i++) tick();
    check("tmo_busy_last", 32'(busy), 1);
    check("tmo_no_rsp_yet", 32'(rsp_vld), 0);
    tick();
    check("tmo_busy_drop", 32'(busy), 0);
    check("tmo_rsp", 32'({rsp_vld, rsp_err, rsp_of, rsp_data}), 32'({1'b1, 1'b1, 1'b0, 8'h00}));
    wait_drain();
    model_on = 1'b1;

    // Back-pressure: 4 queued, 5th held off until a slot frees
    rsp_rdy = 1'b0;
    for (int t = 1; t <= 4; t++) begin
      send(1'b1, 1'b0, {4'h0, 4'(t)}, 8'h20, 4'(t), {4'h2, 4'(t)}, 1'b0, 1'b0);
    end
    cmd_op = 1'b1; cmd_carry = 1'b0; cmd_a = 8'h05; cmd_b = 8'h20; cmd_tag = 4'h5;
    cmd_vld = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("bp_cmd_rdy_low", 32'(cmd_rdy), 0);
    check("bp_idle", 32'(busy), 0);
    check("bp_head_tag", 32'({rsp_vld, rsp_tag}), 32'({1'b1, 4'h1}));
    rsp_rdy = 1'b1;
    n = 0;
    while (!cmd_rdy && n < 20) begin
      tick();
      n++;
    end
    check("bp_cmd_rdy_rise", 32'(cmd_rdy), 1);
    sb_q.push_back({8'h25, 1'b0, 1'b0, 4'h5});
    tick();
    cmd_vld = 1'b0;
    wait_drain();

    // Reset while in WAIT with two responses queued
    rsp_rdy = 1'b0;
    send(1'b1, 1'b0, 8'h01, 8'h02, 4'h6, 8'h03, 1'b0, 1'b0);
    send(1'b1, 1'b0, 8'h03, 8'h04, 4'h7, 8'h07, 1'b0, 1'b0);
    send(1'b1, 1'b0, 8'h05, 8'h06, 4'h8, 8'h11, 1'b0, 1'b0);
    tick();
    check("mid_busy", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_outs", 32'({cmd_rdy, busy, dadder_en, rsp_vld}), 0);
    check("mid_rst_ops", 32'({dadder_op_a, dadder_op_b}), 0);
    check("mid_rst_rsp", 32'({rsp_data, rsp_of, rsp_err, rsp_tag}), 0);
    sb_q.delete();
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    rsp_rdy = 1'b1;
    check("no_stale_rsp", 32'(rsp_vld), 0);
    send(1'b1, 1'b0, 8'h40, 8'h02, 4'hC, 8'h42, 1'b0, 1'b0);
    wait_drain();
    check("post_rst_empty", 32'(rsp_vld), 0);

`ifdef DADDER_DRIVER_STATS_EN
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("stat_clr0", 32'({stat_ops, stat_of}), 0);
    send(1'b1, 1'b0, 8'h11, 8'h22, 4'h1, 8'h33, 1'b0, 1'b0);
    wait_drain();
    send(1'b1, 1'b0, 8'h33, 8'h44, 4'h2, 8'h77, 1'b0, 1'b0);
    wait_drain();
    send(1'b1, 1'b0, 8'hFF, 8'h01, 4'h3, 8'h66, 1'b1, 1'b0);
    wait_drain();
    model_on = 1'b0;
    send(1'b1, 1'b0, 8'h01, 8'h01, 4'h4, 8'h00, 1'b0, 1'b1);
    wait_drain();
    model_on = 1'b1;
    check("stat_ops", 32'(stat_ops), 4);
    check("stat_of", 32'(stat_of), 1);
    check("stat_err", 32'(stat_err), 1);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("stat_clr", 32'({stat_ops, stat_of}), 0);
    check("stat_clr_err", 32'(stat_err), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
